// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: owner state, response flags, defaults.
package imem_arb_pkg;

   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DEBUG = 2'd2
   } owner_t;

   // blank forces the returned word to zero (errors and debug writes)
   typedef struct packed {
      logic err;
      logic blank;
   } rsp_t;

   function automatic int ctr_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive denied debug cycles; flags when debug must be forced.
// Zero latency on at_limit (registered count, combinational compare); no backpressure.
module imem_starve_ctr
   import imem_arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic wait_req,
   input  logic granted,
   output logic at_limit
);

   localparam int CW = ctr_width(LIMIT);
   localparam logic [CW-1:0] MAX = CW'(LIMIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!wait_req || granted) begin
         cnt <= '0;
      end else if (cnt != MAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign at_limit = (cnt == MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/debug arbiter for instruction memory; grant same cycle, response one cycle later.
// No backpressure beyond grant; debug writes compiled in only with IMEM_ARB_DBG_WRITE_EN.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     f_req,
   input  logic [ADDRESS_WIDTH-1:0] f_addr,
   output logic                     f_gnt,
   output logic                     f_rvalid,
   output logic [DATA_WIDTH-1:0]    f_rdata,
   output logic                     f_err,
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [ADDRESS_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0]    d_wdata,
   output logic                     d_gnt,
   output logic                     d_rvalid,
   output logic [DATA_WIDTH-1:0]    d_rdata,
   output logic                     d_err,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     mem_we,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   owner_t                state, state_nx;
   rsp_t                  rsp_q, rsp_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  dbg_starved;
   logic                  misaligned;
   logic                  wr_refused;

   imem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .wait_req (d_req),
      .granted  (d_gnt),
      .at_limit (dbg_starved)
   );

   // Grants are gated by rst_n so nothing is accepted or written while in reset.
   assign d_gnt = rst_n & d_req & (dbg_starved | ~f_req);
   assign f_gnt = rst_n & f_req & ~d_gnt;

   assign mem_addr   = d_gnt ? d_addr : f_addr;
   assign mem_wdata  = d_wdata;
   assign misaligned = (mem_addr[1:0] != 2'b00);

`ifdef IMEM_ARB_DBG_WRITE_EN
   assign mem_we     = d_gnt & d_we & ~misaligned;
   assign wr_refused = 1'b0;
`else
   assign mem_we     = 1'b0;
   assign wr_refused = d_we;
`endif

   assign rsp_d.err   = misaligned | (d_gnt & wr_refused);
   assign rsp_d.blank = rsp_d.err | (d_gnt & d_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OWN_NONE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = OWN_NONE;
      if (f_gnt) begin
         state_nx = OWN_FETCH;
      end else if (d_gnt) begin
         state_nx = OWN_DEBUG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_q   <= '0;
         rdata_q <= '0;
      end else if (f_gnt || d_gnt) begin
         rsp_q   <= rsp_d;
         rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      f_rvalid = 1'b0;
      f_err    = 1'b0;
      f_rdata  = '0;
      d_rvalid = 1'b0;
      d_err    = 1'b0;
      d_rdata  = '0;
      case (state)
         OWN_FETCH: begin
            f_rvalid = 1'b1;
            f_err    = rsp_q.err;
            f_rdata  = rsp_q.blank ? '0 : rdata_q;
         end
         OWN_DEBUG: begin
            d_rvalid = 1'b1;
            d_err    = rsp_q.err;
            d_rdata  = rsp_q.blank ? '0 : rdata_q;
         end
         default: ;
      endcase
   end

endmodule
